data_mem_arbiter: RTL and testbench

Shares the single data memory between the CPU datapath load/store port and a DMA requester.
- CPU has priority.
- DMA is guaranteed progress through a starvation counter.
- DMA may lock the memory for read-modify-write sequences.
- Sits between the datapath's memory-phase signals and the data memory instance.
- Drives a stall to the control unit, which holds PC and register/coproc0 write-enables while stalled.

---
 rtl/data_mem_arbiter_pkg.sv | 19 +
 rtl/data_mem_arbiter_sat_counter.sv | 47 ++++
 rtl/data_mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding and default
// timing limits, also used by the control unit's stall handling.
package data_mem_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_MAX_WAIT = 4;
  localparam int unsigned DEF_LOCK_MAX = 8;
  localparam int unsigned WAIT_W       = 4;
  localparam int unsigned LOCK_W       = 8;

  function automatic logic is_locked(input arb_state_e st);
    return (st == ARB_LOCKED);
  endfunction

endpackage

// File: rtl/data_mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear and load, used for the DMA
// starvation count and the lock hold count.
module sat_counter #(
  parameter int unsigned W   = 4,
  parameter int unsigned MAX = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] MAX_C = W'(MAX);
  localparam logic [W-1:0] ONE_C = W'(1);

  logic [W-1:0] count_r;
  logic [W-1:0] count_nxt_s;

  // Next count: clear beats load beats increment; holds at MAX.
  always_comb begin
    count_nxt_s = count_r;
    if (i_clr) begin
      count_nxt_s = '0;
    end else if (i_load) begin
      count_nxt_s = i_load_val;
    end else if (i_inc && (count_r != MAX_C)) begin
      count_nxt_s = count_r + ONE_C;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Count register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_r <= '0;
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign o_count = count_r;

endmodule

// File: rtl/data_mem_arbiter.sv
// Data-memory arbiter: the CPU load/store port has priority, DMA gets a forced
// single-beat grant after MAX_WAIT denied cycles and may lock for RMW.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT,
  parameter int unsigned LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cpu_read,
  input  logic              i_cpu_write,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_stall,
  input  logic              i_dma_req,
  input  logic              i_dma_we,
  input  logic              i_dma_lock,
  input  logic [ADDR_W-1:0] i_dma_addr,
  input  logic [DATA_W-1:0] i_dma_wdata,
  output logic              o_dma_gnt,
  output logic              o_dma_rvalid,
  output logic [DATA_W-1:0] o_dma_rdata,
  output logic              o_dma_lock_err,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam logic [WAIT_W-1:0] WAIT_MAX_C = WAIT_W'(MAX_WAIT);
  localparam logic [LOCK_W-1:0] LOCK_MAX_C = LOCK_W'(LOCK_MAX);
  localparam logic [LOCK_W-1:0] LOCK_ONE_C = LOCK_W'(1);

  arb_state_e        state_r;
  arb_state_e        state_nxt_s;
  logic              cpu_req_s;
  logic              cpu_stall_s;
  logic              dma_gnt_s;
  logic              lock_enter_s;
  logic              lock_timeout_s;
  logic              relock_block_r;
  logic              lock_err_r;
  logic              dma_rvalid_r;
  logic [DATA_W-1:0] dma_rdata_r;
  logic [WAIT_W-1:0] wait_cnt_s;
  logic [LOCK_W-1:0] lock_cnt_s;
  logic              wait_clr_s;
  logic              lock_clr_s;
  logic              lock_inc_s;

  assign cpu_req_s = i_cpu_read | i_cpu_write;

  // Grant decision and lock state transitions.
  always_comb begin
    state_nxt_s    = state_r;
    dma_gnt_s      = 1'b0;
    lock_enter_s   = 1'b0;
    lock_timeout_s = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        dma_gnt_s = i_dma_req & (~cpu_req_s | (wait_cnt_s == WAIT_MAX_C));
        if (dma_gnt_s && i_dma_lock && !relock_block_r) begin
          lock_enter_s = 1'b1;
          state_nxt_s  = ARB_LOCKED;
        end else begin
          state_nxt_s  = ARB_IDLE;
        end
      end
      ARB_LOCKED: begin
        dma_gnt_s = i_dma_req;
        if (!i_dma_lock) begin
          state_nxt_s = ARB_IDLE;
        end else if (lock_cnt_s == LOCK_MAX_C) begin
          lock_timeout_s = 1'b1;
          state_nxt_s    = ARB_IDLE;
        end else begin
          state_nxt_s = ARB_LOCKED;
        end
      end
      default: begin
        state_nxt_s = ARB_IDLE;
        dma_gnt_s   = 1'b0;
      end
    endcase
  end

  assign cpu_stall_s = cpu_req_s & (dma_gnt_s | is_locked(state_r));

  // Memory port mux; a store wins if the CPU raises read and write together.
  always_comb begin
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (dma_gnt_s) begin
      o_mem_read  = ~i_dma_we;
      o_mem_write = i_dma_we;
      o_mem_addr  = i_dma_addr;
      o_mem_wdata = i_dma_wdata;
    end else if (cpu_req_s && !cpu_stall_s) begin
      o_mem_read  = i_cpu_read & ~i_cpu_write;
      o_mem_write = i_cpu_write;
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_wdata;
    end else begin
      o_mem_read  = 1'b0;
      o_mem_write = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
    end
  end

  // A served beat restarts the starvation count, so forced grants are spaced.
  assign wait_clr_s = dma_gnt_s | ~i_dma_req | lock_timeout_s;
  assign lock_clr_s = (state_nxt_s == ARB_IDLE);
  assign lock_inc_s = is_locked(state_r);

  sat_counter #(
    .W   (WAIT_W),
    .MAX (MAX_WAIT)
  ) u_wait_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (wait_clr_s),
    .i_load     (1'b0),
    .i_load_val ({WAIT_W{1'b0}}),
    .i_inc      (1'b1),
    .o_count    (wait_cnt_s)
  );

  sat_counter #(
    .W   (LOCK_W),
    .MAX (LOCK_MAX)
  ) u_lock_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (lock_clr_s),
    .i_load     (lock_enter_s),
    .i_load_val (LOCK_ONE_C),
    .i_inc      (lock_inc_s),
    .o_count    (lock_cnt_s)
  );

  // State, relock blocking and the lock-error pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r        <= ARB_IDLE;
      relock_block_r <= 1'b0;
      lock_err_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      lock_err_r <= lock_timeout_s;
      if (lock_timeout_s) begin
        relock_block_r <= 1'b1;
      end else if (!i_dma_lock) begin
        relock_block_r <= 1'b0;
      end else begin
        relock_block_r <= relock_block_r;
      end
    end
  end

  // DMA read data capture, one cycle after the granted read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dma_rvalid_r <= 1'b0;
      dma_rdata_r  <= '0;
    end else if (dma_gnt_s && !i_dma_we) begin
      dma_rvalid_r <= 1'b1;
      dma_rdata_r  <= i_mem_rdata;
    end else begin
      dma_rvalid_r <= 1'b0;
      dma_rdata_r  <= dma_rdata_r;
    end
  end

  assign o_cpu_rdata    = i_mem_rdata;
  assign o_cpu_stall    = cpu_stall_s;
  assign o_dma_gnt      = dma_gnt_s;
  assign o_dma_rvalid   = dma_rvalid_r;
  assign o_dma_rdata    = dma_rdata_r;
  assign o_dma_lock_err = lock_err_r;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed testbench for data_mem_arbiter with a small behavioural data memory.
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_req;
  logic        dma_we;
  logic        dma_lock;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic        dma_lock_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:15];
  int checks = 0;
  int errors = 0;

  data_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_WAIT(4), .LOCK_MAX(8)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_read(cpu_read), .i_cpu_write(cpu_write), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
    .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_lock(dma_lock),
    .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata), .o_dma_gnt(dma_gnt),
    .o_dma_rvalid(dma_rvalid), .o_dma_rdata(dma_rdata), .o_dma_lock_err(dma_lock_err),
    .o_mem_read(mem_read), .o_mem_write(mem_write), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs just after the falling edge, then settle.
  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca,
                       input logic [31:0] cwd, input logic dr, input logic dwe,
                       input logic dl, input logic [31:0] da, input logic [31:0] dwd);
    @(negedge clk);
    cpu_read = cr; cpu_write = cw; cpu_addr = ca; cpu_wdata = cwd;
    dma_req = dr; dma_we = dwe; dma_lock = dl; dma_addr = da; dma_wdata = dwd;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
    #3;
    chk("rst_stall", {31'h0, cpu_stall}, 32'h0);
    chk("rst_gnt", {31'h0, dma_gnt}, 32'h0);
    chk("rst_rvalid", {31'h0, dma_rvalid}, 32'h0);
    chk("rst_rdata", dma_rdata, 32'h0);
    chk("rst_lock_err", {31'h0, dma_lock_err}, 32'h0);
    chk("rst_mem_rw", {30'h0, mem_read, mem_write}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: CPU store then load, no DMA
    drive(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t1_st_write", {31'h0, mem_write}, 32'h1);
    chk("t1_st_read", {31'h0, mem_read}, 32'h0);
    chk("t1_st_addr", mem_addr, 32'h10);
    chk("t1_st_wdata", mem_wdata, 32'hDEADBEEF);
    chk("t1_st_stall", {31'h0, cpu_stall}, 32'h0);
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t1_ld_read", {31'h0, mem_read}, 32'h1);
    chk("t1_ld_rdata", cpu_rdata, 32'hDEADBEEF);

    // 2: DMA read on an idle bus
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    chk("t2_gnt", {31'h0, dma_gnt}, 32'h1);
    chk("t2_mem_read", {31'h0, mem_read}, 32'h1);
    chk("t2_mem_addr", mem_addr, 32'h10);
    chk("t2_rvalid_early", {31'h0, dma_rvalid}, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t2_rvalid", {31'h0, dma_rvalid}, 32'h1);
    chk("t2_rdata", dma_rdata, 32'hDEADBEEF);
    chk("t2_gnt_off", {31'h0, dma_gnt}, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t2_rvalid_drop", {31'h0, dma_rvalid}, 32'h0);
    chk("t2_rdata_hold", dma_rdata, 32'hDEADBEEF);

    // 3: starvation, forced grants on cycles 5, 10, 15
    for (int c = 1; c <= 15; c++) begin
      drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      chk($sformatf("t3_gnt_c%0d", c), {31'h0, dma_gnt}, (c % 5 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("t3_stall_c%0d", c), {31'h0, cpu_stall}, (c % 5 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("t3_addr_c%0d", c), mem_addr, (c % 5 == 0) ? 32'h10 : 32'h20);
    end

    // 4: locked read/write/unlock with CPU requesting; lock entered on a forced grant
    drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
      chk($sformatf("t4_wait_stall_c%0d", c), {31'h0, cpu_stall}, 32'h0);
    end
    drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
    chk("t4_b1_gnt", {31'h0, dma_gnt}, 32'h1);
    chk("t4_b1_stall", {31'h0, cpu_stall}, 32'h1);
    drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 1'b1, 32'h14, 32'h12345678);
    chk("t4_b2_gnt", {31'h0, dma_gnt}, 32'h1);
    chk("t4_b2_stall", {31'h0, cpu_stall}, 32'h1);
    chk("t4_b2_write", {31'h0, mem_write}, 32'h1);
    chk("t4_b2_rvalid", {31'h0, dma_rvalid}, 32'h1);
    chk("t4_b2_rdata", dma_rdata, 32'hDEADBEEF);
    drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 32'h14, 32'h0);
    chk("t4_b3_gnt", {31'h0, dma_gnt}, 32'h1);
    chk("t4_b3_stall", {31'h0, cpu_stall}, 32'h1);
    chk("t4_b3_mem_rdata", cpu_rdata, 32'h12345678);
    chk("t4_b3_err", {31'h0, dma_lock_err}, 32'h0);
    drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t4_cpu_stall", {31'h0, cpu_stall}, 32'h0);
    chk("t4_cpu_addr", mem_addr, 32'h20);
    chk("t4_err", {31'h0, dma_lock_err}, 32'h0);
    chk("t4_rdata", dma_rdata, 32'h12345678);

    // 5: lock timeout after 8 locked cycles, then relock blocked
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
    chk("t5_enter_gnt", {31'h0, dma_gnt}, 32'h1);
    for (int c = 1; c <= 8; c++) begin
      drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
      chk($sformatf("t5_lk_stall_c%0d", c), {31'h0, cpu_stall}, 32'h1);
      chk($sformatf("t5_lk_gnt_c%0d", c), {31'h0, dma_gnt}, 32'h1);
      chk($sformatf("t5_lk_err_c%0d", c), {31'h0, dma_lock_err}, 32'h0);
    end
    drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
    chk("t5_to_err", {31'h0, dma_lock_err}, 32'h1);
    chk("t5_to_stall", {31'h0, cpu_stall}, 32'h0);
    chk("t5_to_gnt", {31'h0, dma_gnt}, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
    chk("t5_blk_gnt", {31'h0, dma_gnt}, 32'h1);
    chk("t5_err_pulse", {31'h0, dma_lock_err}, 32'h0);
    drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
    chk("t5_no_relock", {31'h0, cpu_stall}, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
    chk("t5_relock_gnt", {31'h0, dma_gnt}, 32'h1);
    drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
    chk("t5_relock_stall", {31'h0, cpu_stall}, 32'h1);
    chk("t5_relock_rvalid", {31'h0, dma_rvalid}, 32'h1);

    // 6: asynchronous reset while locked
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_stall", {31'h0, cpu_stall}, 32'h0);
    chk("t6_rvalid", {31'h0, dma_rvalid}, 32'h0);
    chk("t6_gnt", {31'h0, dma_gnt}, 32'h0);
    chk("t6_mem_read", {31'h0, mem_read}, 32'h1);
    chk("t6_err", {31'h0, dma_lock_err}, 32'h0);
    @(negedge clk);
    chk("t6_err_hold", {31'h0, dma_lock_err}, 32'h0);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("t6_after_stall", {31'h0, cpu_stall}, 32'h0);
    chk("t6_after_err", {31'h0, dma_lock_err}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
